// File: rtl/spi_move_decoder_pkg.sv
// Shared opcodes, frame length, status bit positions and FSM encoding for the SPI move decoder.
package spi_move_decoder_pkg;

  localparam logic [7:0] OP_MOVE   = 8'h01;
  localparam logic [7:0] OP_STATUS = 8'h02;
  localparam logic [7:0] OP_STOP   = 8'h03;

  localparam int unsigned MOVE_LEN = 6;

  localparam int unsigned ST_OVF   = 7;
  localparam int unsigned ST_ERR   = 6;
  localparam int unsigned ST_FULL  = 5;
  localparam int unsigned ST_EMPTY = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARGS    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

endpackage

// File: rtl/move_fifo.sv
// Show-ahead FIFO of MOVE entries; head, valid, full, empty and count are all registered.
module move_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             ovf_c
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     head_q, head_d;
  logic             valid_q, valid_d, full_q, full_d;
  logic             do_push, do_pop;

  // A push into a full FIFO only succeeds when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && valid_q;
    do_push  = push && (!full_q || do_pop);
    ovf_c    = push && full_q && !do_pop;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    head_d  = mem_d[rd_ptr_d];
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign full  = full_q;
  assign empty = !valid_q;
  assign count = cnt_q;

endmodule

// File: rtl/spi_move_decoder.sv
// Frames SPI bytes into MOVE/STATUS/STOP commands, queues moves for the step generator
// and reports a status byte back to the SPI master.
module spi_move_decoder
  import spi_move_decoder_pkg::*;
#(
  parameter int unsigned STEPS_W    = 16,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MIN_PERIOD = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                byte_received,
  input  logic [7:0]          byte_data,
  input  logic                ssel_active,
  output logic [7:0]          send_data,
  output logic                move_valid,
  input  logic                move_ready,
  output logic                move_dir,
  output logic [STEPS_W-1:0]  move_steps,
  output logic [PERIOD_W-1:0] move_period,
  output logic                abort
);

  localparam int unsigned W     = 1 + STEPS_W + PERIOD_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [2:0] IDX_LAST = 3'(MOVE_LEN - 1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [23:0]         stage_q, stage_d;
  logic                dir_q, dir_d;
  logic                ssel_q;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic                abort_q, abort_d;
  logic [7:0]          send_q, send_d;
  logic                push_c, flush_c, ssel_fall_c;
  logic [STEPS_W-1:0]  steps_c;
  logic [PERIOD_W-1:0] period_raw_c, period_c;
  logic [W-1:0]        wdata_c, head;
  logic                fifo_full, fifo_empty, fifo_ovf_c;
  logic [CNT_W-1:0]    fifo_count;

  // Stage holds steps hi, steps lo, period hi; period lo arrives with the final strobe.
  always_comb begin
    steps_c      = STEPS_W'(stage_q[23:8]);
    period_raw_c = PERIOD_W'({stage_q[7:0], byte_data});
    period_c     = (period_raw_c < MIN_P) ? MIN_P : period_raw_c;
    wdata_c      = {dir_q, steps_c, period_c};
    ssel_fall_c  = ssel_q && !ssel_active;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    dir_d   = dir_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    abort_d = 1'b0;
    push_c  = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (byte_received) begin
          case (byte_data)
            OP_MOVE: begin
              state_d = S_ARGS;
              idx_d   = 3'd1;
            end
            OP_STATUS: begin
              ovf_d = 1'b0;
              err_d = 1'b0;
            end
            OP_STOP: begin
              flush_c = 1'b1;
              abort_d = 1'b1;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DISCARD;
            end
          endcase
        end
      end
      S_ARGS: begin
        if (byte_received) begin
          if (idx_q == 3'd1) dir_d = byte_data[0];
          else               stage_d = {stage_q[15:0], byte_data};
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            push_c  = (steps_c != '0);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (ssel_fall_c) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (ssel_fall_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fifo_ovf_c) ovf_d = 1'b1;
    send_d           = '0;
    send_d[ST_OVF]   = ovf_d;
    send_d[ST_ERR]   = err_d;
    send_d[ST_FULL]  = fifo_full;
    send_d[ST_EMPTY] = fifo_empty;
    send_d[3:0]      = 4'(fifo_count);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stage_q <= '0;
      dir_q   <= 1'b0;
      ssel_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      send_q  <= 8'h10;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      dir_q   <= dir_d;
      ssel_q  <= ssel_active;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      send_q  <= send_d;
    end
  end

  move_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (push_c),
    .wdata (wdata_c),
    .pop   (move_ready),
    .flush (flush_c),
    .head  (head),
    .valid (move_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .ovf_c (fifo_ovf_c)
  );

  assign move_dir    = head[W-1];
  assign move_steps  = head[PERIOD_W +: STEPS_W];
  assign move_period = head[PERIOD_W-1:0];
  assign send_data   = send_q;
  assign abort       = abort_q;

endmodule
